laser_ctrl: RTL

Parametrised player-laser controller for the space invaders pixel pipeline. On a fire request it launches a vertical laser segment above the ship and draws it through the VGA write port. Once per frame it erases the segment, moves it up by a fixed step and redraws it. The laser retires when it leaves the top of the screen or when the collision logic reports a hit. It drives one pixel write per cycle into the same frame-buffer writer the other sprite FSMs use.

---
 rtl/laser_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/laser_ctrl.sv
// Player laser controller: launches a vertical segment above the ship, then erase/move/redraw once per frame.
// Optional macro LASER_AUTOFIRE_EN: fire on the fire level instead of its rising edge.
module laser_ctrl #(
  parameter int          LASER_LEN    = 5,
  parameter int          STEP         = 2,
  parameter int          X_W          = 8,
  parameter int          Y_W          = 7,
  parameter logic [2:0]  LASER_COLOUR = 3'b100,
  parameter logic [2:0]  BG_COLOUR    = 3'b000
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           fire,
  input  logic [X_W-1:0] ship_x,
  input  logic [Y_W-1:0] ship_y,
  input  logic           frame_tick,
  input  logic           hit,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [2:0]     colour,
  output logic           write_en,
  output logic           active,
  output logic [Y_W-1:0] laser_y
);

  typedef enum logic [2:0] {IDLE, DRAW, HOLD, ERASE, MOVE} state_t;

  state_t         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [X_W-1:0] laser_x_q, laser_x_d;
  logic [Y_W-1:0] laser_y_q, laser_y_d;
  logic           kill_q, kill_d;
  logic           fire_go, launch_ok, seg_last;

`ifdef LASER_AUTOFIRE_EN
  assign fire_go = fire;
`else
  logic fire_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fire_q <= 1'b0;
    else          fire_q <= fire;
  end
  assign fire_go = fire & ~fire_q;
`endif

  // A segment that would start above row 0 would wrap, so those launches are refused.
  assign launch_ok = fire_go && (ship_y >= Y_W'(LASER_LEN));
  assign seg_last  = (idx_q == 4'(LASER_LEN - 1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    laser_x_d = laser_x_q;
    laser_y_d = laser_y_q;
    kill_d    = kill_q;
    write_en  = 1'b0;
    x         = '0;
    y         = '0;
    colour    = BG_COLOUR;

    if (state_q != IDLE && hit) kill_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (launch_ok) begin
          laser_x_d = ship_x;
          laser_y_d = ship_y - Y_W'(LASER_LEN);
          idx_d     = '0;
          kill_d    = 1'b0;
          state_d   = DRAW;
        end
      end
      DRAW, ERASE: begin
        write_en = 1'b1;
        x        = laser_x_q;
        y        = laser_y_q + Y_W'(idx_q);
        colour   = (state_q == DRAW) ? LASER_COLOUR : BG_COLOUR;
        if (seg_last) begin
          idx_d = '0;
          if (state_q == DRAW) state_d = HOLD;
          else                 state_d = kill_q ? IDLE : MOVE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      HOLD: begin
        if (kill_q || frame_tick) state_d = ERASE;
      end
      MOVE: begin
        if (laser_y_q < Y_W'(STEP)) begin
          state_d = IDLE;
        end else begin
          laser_y_d = laser_y_q - Y_W'(STEP);
          state_d   = DRAW;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      laser_x_q <= '0;
      laser_y_q <= '0;
      kill_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      laser_x_q <= laser_x_d;
      laser_y_q <= laser_y_d;
      kill_q    <= kill_d;
    end
  end

  assign active  = (state_q != IDLE);
  assign laser_y = laser_y_q;

endmodule
